clk_div_multi: RTL

Parametrised multi-channel clock divider and tick generator: the next generation of the fixed divide-by-50M block. Each channel divides the system clock by a runtime-programmable divisor and produces both a one-cycle enable tick and a toggled divided output. Divisor changes are glitch-free, and all channels can be phase-aligned. It sits next to the board clock and feeds slow timebases (1 Hz, LED blink, debounce, UART baud ticks) to the rest of the design.

---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_channel.sv | 116 +++++++++++
 rtl/clk_div_multi.sv | 54 +++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
//   CNT_W_DEF       : default counter / divisor width (holds 50_000_000)
//   DEFAULT_DIV_DEF : divisor every channel runs at after reset
//   ch_idx_w()      : width of a channel index, never less than one bit
package clk_div_pkg;

    localparam int          CNT_W_DEF       = 26;
    localparam int unsigned DEFAULT_DIV_DEF = 50_000_000;

    // $clog2(1) is 0, but a zero-width select port is not usable, so
    // the index is always at least one bit wide.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 2) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/pending divisor pair, toggled output
// and one-cycle tick.
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-low reset
//   en       in   count enable
//   sync     in   restart: clear count and q, commit any pending divisor
//   load     in   write load_div into the pending divisor
//   load_div in   new divisor value
//   tick     out  registered pulse on each wrap (held high when divisor is 1)
//   q        out  registered output that toggles on each wrap
//   pend     out  a pending divisor is waiting to be committed
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    output logic             tick,
    output logic             q,
    output logic             pend
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W-1:0] div_act_q,  div_act_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic             pend_q,     pend_d;
    logic             q_q,        q_d;
    logic             tick_q,     tick_d;

    logic             div_zero;
    logic             at_last;

    // Compare against div-1 instead of adding to cnt, so a divisor of
    // 2^CNT_W-1 never needs a wider counter.
    assign div_zero = (div_act_q == '0);
    assign at_last  = (cnt_q == (div_act_q - CNT_W'(1)));

    always_comb begin
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        q_d        = q_q;
        tick_d     = 1'b0;

        if (sync) begin
            // Restart wins over counting and loading on this edge.
            cnt_d = '0;
            q_d   = 1'b0;
            if (pend_q) begin
                div_act_d = div_pend_q;
                pend_d    = 1'b0;
            end
        end else begin
            if (pend_q && (!en || div_zero)) begin
                // No wrap will come to commit on: take the new divisor now
                // and start its first period from zero.
                div_act_d = div_pend_q;
                pend_d    = 1'b0;
                cnt_d     = '0;
            end else if (en && div_zero) begin
                cnt_d = '0;
            end else if (en) begin
                if (at_last) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    q_d    = ~q_q;
                    if (pend_q) begin
                        div_act_d = div_pend_q;
                        pend_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // A load only ever lands in the pending slot; the wrap on this
            // same edge has already used the old divisor.
            if (load) begin
                div_pend_d = load_div;
                pend_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            div_act_q  <= DIV_RST;
            div_pend_q <= '0;
            pend_q     <= 1'b0;
            q_q        <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            q_q        <= q_d;
            tick_q     <= tick_d;
        end
    end

    assign tick = tick_q;
    assign q    = q_q;
    assign pend = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / tick generator.
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-low reset
//   en       in   [NUM_CH] per-channel count enable
//   sync     in   restart and phase-align every channel
//   load     in   divisor write strobe
//   load_ch  in   channel addressed by load (out-of-range values ignored)
//   load_div in   [CNT_W] divisor to write
//   tick     out  [NUM_CH] one-cycle pulse every N enabled cycles
//   q        out  [NUM_CH] divided output, period 2N
//   pend     out  [NUM_CH] divisor waiting to be committed
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int         IDX_W       = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              load,
    input  logic [IDX_W-1:0]  load_ch,
    input  logic [CNT_W-1:0]  load_div,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] q,
    output logic [NUM_CH-1:0] pend
);

    logic [NUM_CH-1:0] load_sel;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        // Indices at or above NUM_CH match no channel and are dropped.
        assign load_sel[gi] = load && (load_ch == IDX_W'(gi));

        clk_div_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .en       (en[gi]),
            .sync     (sync),
            .load     (load_sel[gi]),
            .load_div (load_div),
            .tick     (tick[gi]),
            .q        (q[gi]),
            .pend     (pend[gi])
        );
    end

endmodule
